// File: rtl/axi_default_slave.sv
// Default AXI responder: completes any unmapped transaction with DECERR so masters never stall.
// Write (AW/W/B) and read (AR/R) paths run as independent Moore FSMs.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_default_slave #(
  parameter logic [1:0]                RESP_CODE  = 2'b11,
  parameter logic [`AXI_DATA_BITS-1:0] RDATA_FILL = '0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // Write address
  input  logic [`AXI_IDS_BITS-1:0]  AWID,
  input  logic [`AXI_ADDR_BITS-1:0] AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]  AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0] AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  // Write data
  input  logic [`AXI_DATA_BITS-1:0] WDATA,
  input  logic [`AXI_STRB_BITS-1:0] WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  // Write response
  output logic [`AXI_IDS_BITS-1:0]  BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  // Read address
  input  logic [`AXI_IDS_BITS-1:0]  ARID,
  input  logic [`AXI_ADDR_BITS-1:0] ARADDR,
  input  logic [`AXI_LEN_BITS-1:0]  ARLEN,
  input  logic [`AXI_SIZE_BITS-1:0] ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  // Read data
  output logic [`AXI_IDS_BITS-1:0]  RID,
  output logic [`AXI_DATA_BITS-1:0] RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY
);

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} wstate_e;
  typedef enum logic       {StRIdle, StRData} rstate_e;

  wstate_e                    wstate_q;
  rstate_e                    rstate_q;
  logic [`AXI_IDS_BITS-1:0]   bid_q, rid_q;
  logic [`AXI_LEN_BITS-1:0]   rlen_q, rcnt_q;
  logic                       awready_q, wready_q, bvalid_q;
  logic                       arready_q, rvalid_q;

  // Readies come up one cycle after reset release because they are registered.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= StWIdle;
      bid_q     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      unique case (wstate_q)
        StWIdle: begin
          awready_q <= 1'b1;
          if (AWVALID && awready_q) begin
            wstate_q  <= StWData;
            bid_q     <= AWID;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end
        end
        StWData: begin
          if (WVALID && WLAST) begin
            wstate_q <= StWResp;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
          end
        end
        StWResp: begin
          if (BREADY) begin
            wstate_q  <= StWIdle;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
          end
        end
        default: wstate_q <= StWIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q  <= StRIdle;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      unique case (rstate_q)
        StRIdle: begin
          arready_q <= 1'b1;
          if (ARVALID && arready_q) begin
            rstate_q  <= StRData;
            rid_q     <= ARID;
            rlen_q    <= ARLEN;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
          end
        end
        StRData: begin
          if (RREADY) begin
            if (rcnt_q == rlen_q) begin
              rstate_q  <= StRIdle;
              rvalid_q  <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
        end
        default: rstate_q <= StRIdle;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bvalid_q ? RESP_CODE : 2'b00;

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rvalid_q ? RDATA_FILL : '0;
  assign RRESP   = rvalid_q ? RESP_CODE : 2'b00;
  assign RLAST   = rvalid_q && (rcnt_q == rlen_q);

  // Address attributes and write payload are deliberately discarded.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB,
                           ARADDR, ARSIZE, ARBURST};

endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: scoreboard queues of expected B/R responses checked by a monitor,
// plus directed timing checks around handshakes, stalls and reset.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_axi_default_slave;

  logic                      ACLK = 1'b0;
  logic                      ARESET = 1'b1;
  logic [`AXI_IDS_BITS-1:0]  AWID = '0, ARID = '0;
  logic [`AXI_ADDR_BITS-1:0] AWADDR = '0, ARADDR = '0;
  logic [`AXI_LEN_BITS-1:0]  AWLEN = '0, ARLEN = '0;
  logic [`AXI_SIZE_BITS-1:0] AWSIZE = '0, ARSIZE = '0;
  logic [1:0]                AWBURST = 2'b01, ARBURST = 2'b01;
  logic                      AWVALID = 1'b0, ARVALID = 1'b0;
  logic                      AWREADY, ARREADY;
  logic [`AXI_DATA_BITS-1:0] WDATA = '0;
  logic [`AXI_STRB_BITS-1:0] WSTRB = '1;
  logic                      WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic [`AXI_IDS_BITS-1:0]  BID, RID;
  logic [1:0]                BRESP, RRESP;
  logic                      BVALID, BREADY = 1'b0;
  logic [`AXI_DATA_BITS-1:0] RDATA;
  logic                      RLAST, RVALID, RREADY = 1'b0;

  axi_default_slave dut (
    .ACLK    (ACLK),    .ARESET  (ARESET),
    .AWID    (AWID),    .AWADDR  (AWADDR),  .AWLEN   (AWLEN),   .AWSIZE  (AWSIZE),
    .AWBURST (AWBURST), .AWVALID (AWVALID), .AWREADY (AWREADY),
    .WDATA   (WDATA),   .WSTRB   (WSTRB),   .WLAST   (WLAST),   .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BID     (BID),     .BRESP   (BRESP),   .BVALID  (BVALID),  .BREADY  (BREADY),
    .ARID    (ARID),    .ARADDR  (ARADDR),  .ARLEN   (ARLEN),   .ARSIZE  (ARSIZE),
    .ARBURST (ARBURST), .ARVALID (ARVALID), .ARREADY (ARREADY),
    .RID     (RID),     .RDATA   (RDATA),   .RRESP   (RRESP),   .RLAST   (RLAST),
    .RVALID  (RVALID),  .RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  int r_seen   = 0;
  int b_seen   = 0;
  int w_acc    = 0;

  logic [`AXI_IDS_BITS-1:0] bq[$];
  logic [`AXI_IDS_BITS:0]   rq[$];  // {id, last}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // Monitor: samples on the falling edge, between input updates and the active edge.
  initial begin
    logic [`AXI_IDS_BITS:0] r_exp;
    logic [`AXI_IDS_BITS-1:0] b_exp;
    logic [63:0] r_prev, b_prev;
    logic r_stall, b_stall;
    r_stall = 1'b0;
    b_stall = 1'b0;
    r_prev  = '0;
    b_prev  = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        rq.delete();
        bq.delete();
        r_stall = 1'b0;
        b_stall = 1'b0;
      end else begin
        if (r_stall) check_eq("r_hold", {RVALID, RID, RLAST, RRESP, RDATA}, r_prev);
        if (b_stall) check_eq("b_hold", {BVALID, BID, BRESP}, b_prev);
        if (WVALID && WREADY) w_acc++;
        if (RVALID && RREADY) begin
          r_seen++;
          if (rq.size() == 0) check_eq("r_extra_beat", RVALID, 1'b0);
          else begin
            r_exp = rq.pop_front();
            check_eq("rid", RID, r_exp[`AXI_IDS_BITS:1]);
            check_eq("rlast", RLAST, r_exp[0]);
            check_eq("rresp", RRESP, 2'b11);
            check_eq("rdata", RDATA, 32'h0);
          end
        end
        if (BVALID && BREADY) begin
          b_seen++;
          if (bq.size() == 0) check_eq("b_extra_resp", BVALID, 1'b0);
          else begin
            b_exp = bq.pop_front();
            check_eq("bid", BID, b_exp);
            check_eq("bresp", BRESP, 2'b11);
          end
        end
        r_stall = RVALID && !RREADY;
        b_stall = BVALID && !BREADY;
        r_prev  = {RVALID, RID, RLAST, RRESP, RDATA};
        b_prev  = {BVALID, BID, BRESP};
      end
    end
  end

  task automatic do_aw(input logic [7:0] id);
    int k = 0;
    AWVALID = 1'b1;
    AWID    = id;
    AWLEN   = 4'd7;
    while (!AWREADY && k < 50) begin cyc(1); k++; end
    if (!AWREADY) check_eq("aw_timeout", AWREADY, 1'b1);
    else bq.push_back(id);
    cyc(1);
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      repeat (gap) begin WVALID = 1'b0; cyc(1); end
      WVALID = 1'b1;
      WLAST  = (i == n - 1);
      WDATA  = $urandom;
      while (!WREADY && k < 50) begin cyc(1); k++; end
      if (!WREADY) check_eq("w_timeout", WREADY, 1'b1);
      cyc(1);
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    check_eq("wready_after_last", WREADY, 1'b0);
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [3:0] len);
    int k = 0;
    ARVALID = 1'b1;
    ARID    = id;
    ARLEN   = len;
    while (!ARREADY && k < 50) begin cyc(1); k++; end
    if (!ARREADY) check_eq("ar_timeout", ARREADY, 1'b1);
    else for (int i = 0; i <= int'(len); i++) rq.push_back({id, i == int'(len)});
    cyc(1);
    ARVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((rq.size() != 0 || bq.size() != 0) && k < 300) begin cyc(1); k++; end
    check_eq("drain", rq.size() + bq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, b0, w0;

    // Reset state
    cyc(2);
    check_eq("rst_awready", AWREADY, 1'b0);
    check_eq("rst_arready", ARREADY, 1'b0);
    check_eq("rst_valids", {WREADY, BVALID, RVALID}, 3'b000);
    ARESET = 1'b0;
    cyc(1);
    check_eq("post_rst_ready", {AWREADY, ARREADY}, 2'b11);
    check_eq("post_rst_others", {WREADY, BVALID, RVALID, RLAST, BID, RID, BRESP, RRESP, RDATA},
             '0);

    // Single write
    BREADY = 1'b1;
    do_aw(8'h25);
    check_eq("aw_then_wready", {AWREADY, WREADY}, 2'b01);
    do_w(1, 0);
    check_eq("bvalid_after_wlast", BVALID, 1'b1);
    cyc(1);
    check_eq("b_done", {BVALID, AWREADY}, 2'b01);

    // Burst read, 16 beats back to back
    RREADY = 1'b1;
    do_ar(8'h13, 4'd15);
    check_eq("rvalid_first", RVALID, 1'b1);
    n = 0;
    while (rq.size() != 0 && n < 100) begin cyc(1); n++; end
    check_eq("burst_cycles", n, 16);
    check_eq("burst_idle", {RVALID, ARREADY}, 2'b01);

    // Back-pressure on both channels concurrently
    r0 = r_seen;
    b0 = b_seen;
    RREADY = 1'b0;
    BREADY = 1'b0;
    fork
      do_ar(8'h31, 4'd3);
      for (int i = 0; i < 24; i++) begin RREADY = (i % 3 == 0); cyc(1); end
      begin
        do_aw(8'h44);
        do_w(4, 1);
        cyc(5);
        check_eq("b_held", BVALID, 1'b1);
        BREADY = 1'b1;
        cyc(1);
        check_eq("b_released", BVALID, 1'b0);
      end
    join
    RREADY = 1'b1;
    wait_idle();
    cyc(2);
    check_eq("bp_r_beats", r_seen - r0, 4);
    check_eq("bp_b_resps", b_seen - b0, 1);

    // Simultaneous AW and AR
    AWVALID = 1'b1; AWID = 8'h01;
    ARVALID = 1'b1; ARID = 8'h02; ARLEN = 4'd2;
    check_eq("both_ready", {AWREADY, ARREADY}, 2'b11);
    bq.push_back(8'h01);
    for (int i = 0; i <= 2; i++) rq.push_back({8'h02, i == 2});
    cyc(1);
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    check_eq("both_accepted", {AWREADY, ARREADY, WREADY, RVALID}, 4'b0011);
    do_w(1, 0);
    wait_idle();

    // Burst write with an extra W offered after WLAST
    w0 = w_acc;
    b0 = b_seen;
    BREADY = 1'b0;
    do_aw(8'h57);
    do_w(8, 0);
    check_eq("bw_beats", w_acc - w0, 8);
    WVALID = 1'b1;
    cyc(2);
    WVALID = 1'b0;
    check_eq("bw_no_extra", w_acc - w0, 8);
    BREADY = 1'b1;
    wait_idle();
    cyc(2);
    check_eq("bw_one_resp", b_seen - b0, 1);

    // Reset in the middle of a read burst
    do_ar(8'h66, 4'd7);
    cyc(2);
    ARESET = 1'b1;
    cyc(3);
    check_eq("midrst_rvalid", RVALID, 1'b0);
    ARESET = 1'b0;
    cyc(1);
    check_eq("midrst_release", {RVALID, ARREADY, AWREADY}, 3'b011);
    r0 = r_seen;
    do_ar(8'h67, 4'd0);
    wait_idle();
    cyc(3);
    check_eq("midrst_one_beat", r_seen - r0, 1);
    check_eq("midrst_idle", {RVALID, ARREADY}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_default_slave.md
# axi_default_slave

Terminating responder behind the interconnect's default route: every read or write whose address matches no mapped slave range is delivered here. The block completes the transaction legally so the issuing master never hangs. It accepts the address, sinks all write beats, returns DECERR on B, and returns ARLEN+1 DECERR read beats with a correct RLAST. Read and write paths are independent FSMs and may be active in the same cycle.

## Interface
- `RESP_CODE`, default 2'b11: value driven on BRESP/RRESP (DECERR).
- `RDATA_FILL`, default 32'h0000_0000: constant driven on RDATA for every read beat.
- Widths come from the AXI defines: ID = `AXI_IDS_BITS`, address = `AXI_ADDR_BITS`, data = `AXI_DATA_BITS`, length = `AXI_LEN_BITS`, size = `AXI_SIZE_BITS`, strobe = `AXI_STRB_BITS`.

- `ACLK` in 1: single clock, rising edge.
- `ARESET` in 1: reset, synchronous and active-high.
- `AWID` in IDS: write ID, latched.
- `AWADDR` in ADDR: ignored.
- `AWLEN` in LEN: ignored; WLAST terminates the burst.
- `AWSIZE`, `AWBURST` in SIZE/2: ignored.
- `AWVALID` in 1, `AWREADY` out 1: write address handshake.
- `WDATA` in DATA, `WSTRB` in STRB: discarded.
- `WLAST` in 1: final write beat.
- `WVALID` in 1, `WREADY` out 1: write data handshake.
- `BID` out IDS, `BRESP` out 2: write response.
- `BVALID` out 1, `BREADY` in 1: write response handshake.
- `ARID` in IDS: read ID, latched.
- `ARLEN` in LEN: read burst length, latched.
- `ARADDR`, `ARSIZE`, `ARBURST`: ignored.
- `ARVALID` in 1, `ARREADY` out 1: read address handshake.
- `RID` out IDS, `RDATA` out DATA, `RRESP` out 2, `RLAST` out 1: read data beat.
- `RVALID` out 1, `RREADY` in 1: read data handshake.

## Operation
- Write FSM, states WIDLE, WDATA, WRESP.
  - WIDLE: AWREADY=1. On AWVALID&&AWREADY, latch AWID and move to WDATA.
  - WDATA: WREADY=1. Each WVALID&&WREADY beat is discarded. On a beat with WLAST=1, move to WRESP.
  - WRESP: BVALID=1, BID=latched ID, BRESP=RESP_CODE. On BREADY, move to WIDLE.
  - W beats are never accepted before the AW handshake; the interconnect forwards W only after AW.
- Read FSM, states RIDLE, RDATA.
  - RIDLE: ARREADY=1. On the AR handshake, latch ARID and ARLEN, clear the beat counter, and move to RDATA.
  - RDATA: RVALID=1, RID=latched ID, RDATA=RDATA_FILL, RRESP=RESP_CODE.
  - RLAST = (beat counter == latched ARLEN).
  - On RVALID&&RREADY: if RLAST, move to RIDLE; otherwise the counter increments.
  - The counter is `AXI_LEN_BITS` wide and cannot wrap, because it stops at ARLEN (maximum 15 gives 16 beats).
- All outputs are Moore, decoded from state and latched registers. No combinational path runs from any input to any output.
- The write and read FSMs share no state. Simultaneous AW and AR handshakes in one cycle are both accepted.

## Timing
- Reset: while ARESET=1 at a clock edge, both FSMs go to IDLE, latched IDs/len/counter go to 0, and all VALID and READY outputs are 0.
- In the first cycle after ARESET deasserts, AWREADY=1 and ARREADY=1. All other outputs are 0.
- AW handshake in cycle T gives AWREADY=0 and WREADY=1 in cycle T+1.
- WLAST beat in cycle T gives WREADY=0 and BVALID=1 in cycle T+1.
- BREADY in cycle T gives BVALID=0 and AWREADY=1 in cycle T+1.
- Minimum write transaction: AW, one W beat, B, back in WIDLE, taking 3 cycles.
- AR handshake in cycle T gives the first RVALID in cycle T+1.
- With RREADY held high, beats stream one per cycle: ARLEN+1 consecutive cycles, RLAST only on the last.
- Back-pressure: while VALID=1 and READY=0, every B or R output holds stable. RVALID/BVALID never drop without a handshake.
- Reset asserted mid-burst aborts the transaction with no response. This is a legal termination because the whole system resets together.
- ID, RESP, and RDATA outputs show the latched or constant values only while the corresponding VALID is high. Otherwise they are don't-care, but must be driven (not X) after reset.

## Test plan
- Reset: assert ARESET 3 cycles mid-read (ARLEN=7, beat 3) -> next cycle after release RVALID=0, ARREADY=1, AWREADY=1; a new AR with ARLEN=0 returns exactly 1 beat.
- Single write: AWID=8'h25, one W beat with WLAST=1, BREADY=1 -> BVALID one cycle after WLAST, BID=8'h25, BRESP=2'b11, AWREADY=1 the cycle after.
- Burst read: ARID=8'h13, ARLEN=4'd15, RREADY=1 -> 16 beats on consecutive cycles, RID=8'h13, RRESP=2'b11, RDATA=32'h0, RLAST only on beat 16.
- Back-pressure: ARLEN=3 with RREADY toggling 1,0,0,1,... and a 4-beat write with WVALID gaps and BREADY delayed 5 cycles -> outputs hold stable while stalled, exactly 4 R beats, one B response.
- Concurrency: AW (ID 8'h01) and AR (ID 8'h02, ARLEN=2) handshake in the same cycle -> both accepted, R stream and B response complete independently with correct IDs.
- Burst write: AWLEN=4'd7 with 8 W beats, WLAST on beat 8 -> WREADY high for all 8 beats, exactly one BVALID, no extra beat accepted after WLAST.
